// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event arbiter.
// KEY_RELEASE_EVENTS_EN selects press+release events with a two-deep per-key queue.
package key_event_pkg;

   typedef enum logic {
      EV_RELEASE = 1'b0,
      EV_PRESS   = 1'b1
   } ev_type_t;

   typedef struct packed {
      logic [1:0] cnt;
      ev_type_t   first;
   } key_q_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_VALID = 1'b1
   } out_state_t;

`ifdef KEY_RELEASE_EVENTS_EN
   localparam int KEY_Q_DEPTH = 2;
`else
   localparam int KEY_Q_DEPTH = 1;
`endif

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchroniser for one raw key, followed by a history flop
// that turns the synchronised level into single-cycle press/release edges.
module key_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic press_edge,
   output logic release_edge
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign press_edge   = sync2 & ~prev;
   assign release_edge = ~sync2 & prev;

endmodule

// File: rtl/key_event_arbiter.sv
// Serialises key press/release edges from N_KEYS inputs into one valid/ready stream.
// Build option: KEY_RELEASE_EVENTS_EN (release events + queue depth 2); default is presses only.
module key_event_arbiter
   import key_event_pkg::*;
#(
   parameter int N_KEYS = 4,
   parameter int KW     = $clog2(N_KEYS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] keys,
   output logic              ev_valid,
   output logic [KW-1:0]     ev_key,
   output logic              ev_press,
   input  logic              ev_ready,
   output logic              overflow
);

   logic [N_KEYS-1:0] press_edge;
   logic [N_KEYS-1:0] release_edge;
   logic [N_KEYS-1:0] new_edge;
   key_q_t            q    [N_KEYS];
   key_q_t            q_nx [N_KEYS];
   out_state_t        state;
   out_state_t        state_nx;
   logic [KW-1:0]     rr_ptr;
   logic [KW-1:0]     grant;
   logic              any_pending;
   logic              pop;
   logic              ovf_nx;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_sync
      key_edge_sync u_sync (
         .clk          (clk),
         .reset        (reset),
         .key          (keys[k]),
         .press_edge   (press_edge[k]),
         .release_edge (release_edge[k])
      );
   end

`ifdef KEY_RELEASE_EVENTS_EN
   assign new_edge = press_edge | release_edge;
`else
   logic unused_release;
   assign unused_release = ^release_edge;
   assign new_edge       = press_edge;
`endif

   // Walk from rr_ptr+N down to rr_ptr+1 so the nearest key after rr_ptr is written last and wins.
   always_comb begin
      any_pending = 1'b0;
      grant       = '0;
      for (int i = N_KEYS; i >= 1; i--) begin
         if (q[(int'(rr_ptr) + i) % N_KEYS].cnt != 2'd0) begin
            any_pending = 1'b1;
            grant       = KW'((int'(rr_ptr) + i) % N_KEYS);
         end
      end
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      case (state)
         S_IDLE: begin
            if (any_pending) begin
               pop      = 1'b1;
               state_nx = S_VALID;
            end
         end
         S_VALID: begin
            if (ev_ready) begin
               if (any_pending) pop = 1'b1;
               else             state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Pop is applied before the enqueue so a same-cycle edge sees the post-pop count.
   always_comb begin
      ovf_nx = overflow;
      for (int k = 0; k < N_KEYS; k++) begin
         q_nx[k] = q[k];
         if (pop && (grant == KW'(k))) begin
            q_nx[k].cnt   = q[k].cnt - 2'd1;
            q_nx[k].first = ev_type_t'(~q[k].first);
         end
         if (new_edge[k]) begin
            if (q_nx[k].cnt == 2'd0) begin
               q_nx[k].cnt   = 2'd1;
               q_nx[k].first = ev_type_t'(press_edge[k]);
            end else if (q_nx[k].cnt < 2'(KEY_Q_DEPTH)) begin
               q_nx[k].cnt = q_nx[k].cnt + 2'd1;
            end else begin
`ifdef KEY_RELEASE_EVENTS_EN
               q_nx[k].cnt = q_nx[k].cnt - 2'd1;
`endif
               ovf_nx = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         ev_key   <= '0;
         rr_ptr   <= KW'(N_KEYS - 1);
         overflow <= 1'b0;
         for (int k = 0; k < N_KEYS; k++) q[k] <= '0;
      end else begin
         state    <= state_nx;
         overflow <= ovf_nx;
         for (int k = 0; k < N_KEYS; k++) q[k] <= q_nx[k];
         if (pop) begin
            ev_key <= grant;
            rr_ptr <= grant;
         end
      end
   end

`ifdef KEY_RELEASE_EVENTS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)    ev_press <= 1'b0;
      else if (pop) ev_press <= q[grant].first;
   end
`else
   assign ev_press = 1'b1;
`endif

   assign ev_valid = (state == S_VALID);

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: directed key patterns push expected
// events, a negedge monitor pops and compares on every accepted handshake.
module tb_key_event_arbiter;

   localparam int N_KEYS = 4;
   localparam int KW     = 2;

   typedef struct {
      logic [KW-1:0] key;
      logic          press;
   } exp_t;

   logic              clk;
   logic              reset;
   logic [N_KEYS-1:0] keys;
   logic              ev_valid;
   logic [KW-1:0]     ev_key;
   logic              ev_press;
   logic              ev_ready;
   logic              overflow;

   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];

`ifdef KEY_RELEASE_EVENTS_EN
   localparam logic RESET_PRESS = 1'b0;
   localparam bit   REL_EN      = 1'b1;
`else
   localparam logic RESET_PRESS = 1'b1;
   localparam bit   REL_EN      = 1'b0;
`endif

   key_event_arbiter #(.N_KEYS(N_KEYS)) dut (
      .clk      (clk),
      .reset    (reset),
      .keys     (keys),
      .ev_valid (ev_valid),
      .ev_key   (ev_key),
      .ev_press (ev_press),
      .ev_ready (ev_ready),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every accepted handshake must match the oldest expected event.
   always @(negedge clk) begin
      if (!reset && ev_valid && ev_ready) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: got key=%0d press=%0d, expected no event", ev_key, ev_press);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            if (ev_key !== e.key || ev_press !== e.press) begin
               errors++;
               $display("[TB] FAIL event: got key=%0d press=%0d, expected key=%0d press=%0d",
                        ev_key, ev_press, e.key, e.press);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [N_KEYS-1:0] k, input logic rdy, input int cycles);
      keys     = k;
      ev_ready = rdy;
      tick(cycles);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic pushExp(input int key, input logic press);
      exp_t e;
      e.key   = KW'(key);
      e.press = press;
      expQ.push_back(e);
   endtask

   task automatic resetDut();
      reset    = 1'b1;
      keys     = '0;
      ev_ready = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n;
      n = 0;
      while ((expQ.size() != 0 || ev_valid) && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (expQ.size() != 0 || ev_valid) begin
         errors++;
         $display("[TB] FAIL %s: %0d events still expected, ev_valid=%0d after %0d cycles",
                  name, expQ.size(), ev_valid, budget);
         expQ.delete();
      end
   endtask

   initial begin
      reset    = 1'b1;
      keys     = '0;
      ev_ready = 1'b0;
      tick(2);
      checkOutput("reset_valid", 32'(ev_valid), 32'd0);
      checkOutput("reset_key", 32'(ev_key), 32'd0);
      checkOutput("reset_press", 32'(ev_press), 32'(RESET_PRESS));
      checkOutput("reset_overflow", 32'(overflow), 32'd0);
      reset = 1'b0;

      $display("[TB] idle after reset, then single key 1 press");
      ev_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         checkOutput("idle_valid", 32'(ev_valid), 32'd0);
      end
      pushExp(1, 1'b1);
      keys = 4'b0010;
      tick(3);
      checkOutput("latency_not_yet", 32'(ev_valid), 32'd0);
      tick(1);
      checkOutput("latency_valid", 32'(ev_valid), 32'd1);
      checkOutput("latency_key", 32'(ev_key), 32'd1);
      waitDrain("drain_single", 20);
      resetDut();

      $display("[TB] all four keys pressed together");
      for (int k = 0; k < N_KEYS; k++) pushExp(k, 1'b1);
      applyStimulus(4'b1111, 1'b1, 1);
      waitDrain("drain_all_keys", 30);
      resetDut();

      $display("[TB] hold with ready low, then back-to-back");
      applyStimulus(4'b0101, 1'b0, 4);
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_valid", 32'(ev_valid), 32'd1);
         checkOutput("hold_key", 32'(ev_key), 32'd0);
         checkOutput("hold_press", 32'(ev_press), 32'd1);
         tick(1);
      end
      pushExp(0, 1'b1);
      pushExp(2, 1'b1);
      applyStimulus(4'b0101, 1'b1, 1);
      checkOutput("b2b_valid", 32'(ev_valid), 32'd1);
      checkOutput("b2b_key", 32'(ev_key), 32'd2);
      tick(1);
      checkOutput("b2b_idle", 32'(ev_valid), 32'd0);
      waitDrain("drain_b2b", 20);
      resetDut();

      $display("[TB] queue overflow on key 3 while output is busy");
      applyStimulus(4'b0001, 1'b0, 4);
      applyStimulus(4'b1001, 1'b0, 3);
      applyStimulus(4'b0001, 1'b0, 3);
      checkOutput("no_overflow_yet", 32'(overflow), 32'd0);
      applyStimulus(4'b1001, 1'b0, 3);
      checkOutput("overflow_set", 32'(overflow), 32'd1);
      pushExp(0, 1'b1);
      pushExp(3, 1'b1);
      applyStimulus(4'b1001, 1'b1, 1);
      waitDrain("drain_overflow", 20);
      tick(3);
      checkOutput("overflow_sticky", 32'(overflow), 32'd1);
      resetDut();
      checkOutput("overflow_cleared", 32'(overflow), 32'd0);

      $display("[TB] press then release of key 1");
      pushExp(1, 1'b1);
      if (REL_EN) pushExp(1, 1'b0);
      applyStimulus(4'b0010, 1'b1, 6);
      applyStimulus(4'b0000, 1'b1, 6);
      waitDrain("drain_release", 20);
      resetDut();

      $display("[TB] reset during a presented event");
      applyStimulus(4'b0111, 1'b0, 6);
      checkOutput("pre_reset_valid", 32'(ev_valid), 32'd1);
      checkOutput("pre_reset_key", 32'(ev_key), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("async_reset_valid", 32'(ev_valid), 32'd0);
      keys = '0;
      tick(2);
      reset    = 1'b0;
      ev_ready = 1'b1;
      tick(10);
      checkOutput("post_reset_valid", 32'(ev_valid), 32'd0);
      checkOutput("post_reset_queue", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
